ghr_ckpt_unit: RTL and testbench
================================

# ghr_ckpt_unit

Speculative global-history register with in-order checkpointing and misprediction recovery, the parametrised successor to the plain shift-only GHR. It sits between the branch predictor front end (which shifts predicted outcomes in) and the backend branch resolution / commit logic (which retires or repairs history). It maintains two histories:
- Speculative: fed to the predictor index hash.
- Architectural: committed only.

## Interface

Parameters
- GHR_WIDTH, 8, history length in bits; must be ≥ 2.
- CKPT_DEPTH, 8, number of in-flight branch checkpoints; power of two, ≥ 2.
- TAG_W, $clog2(CKPT_DEPTH), checkpoint tag width (derived; do not override).

Ports
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_valid  in  1  predictor presents a branch prediction this cycle.
- pred_taken  in  1  predicted direction.
- pred_ready  out  1  checkpoint slot available and no recovery/flush this cycle.
- pred_tag  out  TAG_W  tag allocated to the current prediction (equals tail pointer).
- commit_valid  in  1  oldest in-flight branch retires.
- commit_taken  in  1  resolved direction of the retiring branch.
- recover_valid  in  1  branch with recover_tag mispredicted.
- recover_tag  in  TAG_W  tag of the mispredicted branch.
- recover_taken  in  1  correct direction of the mispredicted branch.
- flush  in  1  full pipeline flush; discard all speculation.
- ghr_spec  out  GHR_WIDTH  speculative history, LSB = youngest outcome.
- ghr_arch  out  GHR_WIDTH  committed history, LSB = youngest outcome.
- ckpt_count  out  TAG_W+1  number of in-flight checkpoints.

## Operation

- State:
  - ckpt[CKPT_DEPTH] of GHR_WIDTH.
  - head and tail pointers (TAG_W, wrap modulo CKPT_DEPTH).
  - count (TAG_W+1).
  - ghr_spec, ghr_arch.
- Reset: ghr_spec = 0, ghr_arch = 0, head = tail = 0, count = 0, so pred_ready = 1 and pred_tag = 0. Checkpoint contents are don't-care.
- pred_ready = (count < CKPT_DEPTH) && !recover_valid && !flush (combinational).
- Predict (pred_valid && pred_ready):
  - ckpt[tail] ← ghr_spec (pre-shift value).
  - ghr_spec ← {ghr_spec[GHR_WIDTH-2:0], pred_taken}.
  - tail++ and count++.
  - pred_valid while !pred_ready is ignored; no state change.
- Commit (commit_valid && count > 0):
  - ghr_arch ← {ghr_arch[GHR_WIDTH-2:0], commit_taken}.
  - head++ and count--.
  - Commit at count = 0 is ignored.
- Recover (recover_valid, tag must be in flight):
  - ghr_spec ← {ckpt[recover_tag][GHR_WIDTH-2:0], recover_taken}.
  - tail ← recover_tag + 1; all younger checkpoints are freed.
  - count ← ((recover_tag − head) mod CKPT_DEPTH) + 1.
  - A recover_tag outside [head, tail) is illegal and the behaviour is undefined; the bench asserts against it.
- Flush: ghr_spec ← ghr_arch (pre-commit value of this cycle), tail ← head, count ← 0.
- Priority and simultaneity:
  - flush > recover > predict; predict is suppressed by pred_ready.
  - Commit is processed in parallel with any of these:
    - Under flush: ghr_arch still updates, head advances, count ends at 0 and tail ← new head. Commit at count = 0 is still ignored.
    - Under recover: count ends at the recover formula minus 1. The recovered ghr_spec uses the checkpoint read before the commit frees that slot.
- Wrap-around: pointers wrap naturally. Full is count = CKPT_DEPTH with head = tail; empty is count = 0 with head = tail. Count alone disambiguates the two.

## Timing

- All outputs except pred_ready and pred_tag are registered.
- pred_tag = tail (registered); pred_ready is combinational from count, recover_valid and flush.
- Predict, commit, recover and flush each take effect one cycle after the sampling edge; ghr_spec reflects a prediction at cycle N+1.
- Back-to-back predictions every cycle are supported until count = CKPT_DEPTH.
- Recovery uses a single-cycle checkpoint read (async or flop array), so there are no bubbles beyond the recover cycle itself.
- rst asserted mid-operation overrides everything on that edge: all in-flight checkpoints are discarded and outputs return to reset values the next cycle.

## Test plan

- Reset, then 3 predictions T,N,T with GHR_WIDTH=8:
  - ghr_spec = 8'b0000_0101; tags issued 0,1,2; ckpt_count = 3; ghr_arch = 0.
- Fill to 8 in-flight predictions:
  - pred_ready = 0 and ckpt_count = 8.
  - A 9th pred_valid changes nothing.
  - One commit re-raises pred_ready next cycle; pred_tag = 0 (wrapped).
- Predict T,T,T,T (tags 0–3), then recover_tag = 1 with recover_taken = 0:
  - ghr_spec = 8'b0000_0010; ckpt_count = 2; next pred_tag = 2.
- Predict T,N (ghr_spec = 8'b10), commit T, then flush:
  - ghr_arch = 8'b1; ghr_spec = 8'b1; ckpt_count = 0; pred_ready = 1.
- Simultaneous events:
  - Commit plus recover in one cycle (head = 0, recover_tag = 2): count = 2 and ghr_arch shifted.
  - Predict plus recover in one cycle: the prediction is dropped (pred_ready = 0).
  - Commit at count = 0: ignored.
- rst asserted with 5 checkpoints in flight and ghr_spec nonzero:
  - Next cycle all outputs are at reset values and pred_tag = 0.

Source files
------------

// File: rtl/ghr_ckpt_unit.sv
// Speculative/architectural global-history register pair with an in-order
// checkpoint ring for misprediction recovery and full-flush repair.
module ghr_ckpt_unit #(
  parameter int unsigned GHR_WIDTH  = 8,
  parameter int unsigned CKPT_DEPTH = 8,
  parameter int unsigned TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic                 pred_taken,
  output logic                 pred_ready,
  output logic [TAG_W-1:0]     pred_tag,
  input  logic                 commit_valid,
  input  logic                 commit_taken,
  input  logic                 recover_valid,
  input  logic [TAG_W-1:0]     recover_tag,
  input  logic                 recover_taken,
  input  logic                 flush,
  output logic [GHR_WIDTH-1:0] ghr_spec,
  output logic [GHR_WIDTH-1:0] ghr_arch,
  output logic [TAG_W:0]       ckpt_count
);

  localparam logic [TAG_W-1:0] TagOne  = TAG_W'(1);
  localparam logic [TAG_W:0]   CntOne  = (TAG_W + 1)'(1);
  localparam logic [TAG_W:0]   CntFull = (TAG_W + 1)'(CKPT_DEPTH);

  logic [GHR_WIDTH-1:0] ckpt_q [CKPT_DEPTH];
  logic [GHR_WIDTH-1:0] spec_q, spec_d;
  logic [GHR_WIDTH-1:0] arch_q, arch_d;
  logic [TAG_W-1:0]     head_q, head_d;
  logic [TAG_W-1:0]     tail_q, tail_d;
  logic [TAG_W:0]       count_q, count_d;
  logic [TAG_W-1:0]     recover_dist;
  logic                 do_pred;
  logic                 do_commit;

  assign pred_ready   = (count_q < CntFull) && !recover_valid && !flush;
  assign do_pred      = pred_valid && pred_ready;
  assign do_commit    = commit_valid && (count_q != '0);
  assign recover_dist = recover_tag - head_q;

  assign pred_tag   = tail_q;
  assign ghr_spec   = spec_q;
  assign ghr_arch   = arch_q;
  assign ckpt_count = count_q;

  always_comb begin
    spec_d  = spec_q;
    arch_d  = arch_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (do_commit) begin
      arch_d = {arch_q[GHR_WIDTH-2:0], commit_taken};
      head_d = head_q + TagOne;
    end

    if (flush) begin
      // Repair from the pre-commit architectural history of this cycle.
      spec_d  = arch_q;
      tail_d  = head_d;
      count_d = '0;
    end else if (recover_valid) begin
      spec_d  = {ckpt_q[recover_tag][GHR_WIDTH-2:0], recover_taken};
      tail_d  = recover_tag + TagOne;
      count_d = {1'b0, recover_dist} + CntOne;
      if (do_commit) count_d = count_d - CntOne;
    end else begin
      if (do_pred) begin
        spec_d  = {spec_q[GHR_WIDTH-2:0], pred_taken};
        tail_d  = tail_q + TagOne;
        count_d = count_q + CntOne;
      end
      if (do_commit) count_d = count_d - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_q  <= '0;
      arch_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      spec_q  <= spec_d;
      arch_q  <= arch_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Checkpoint contents need no reset; stale slots are never read legally.
  always_ff @(posedge clk) begin
    if (do_pred) ckpt_q[tail_q] <= spec_q;
  end

endmodule

// File: tb/tb_ghr_ckpt_unit.sv
// Bench for ghr_ckpt_unit: directed scenarios plus a randomized run checked
// against a queue-based model of the in-flight branch window.
module tb_ghr_ckpt_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid, pred_taken, pred_ready;
  logic [2:0] pred_tag;
  logic       commit_valid, commit_taken;
  logic       recover_valid, recover_taken;
  logic [2:0] recover_tag;
  logic       flush;
  logic [7:0] ghr_spec, ghr_arch;
  logic [3:0] ckpt_count;

  int errors = 0;
  int checks = 0;

  // Model: queue of checkpoint snapshots, oldest first; tag = (head + index) mod 8.
  int m_q[$];
  int m_head, m_spec, m_arch;
  bit obs_ready, exp_ready;
  int obs_tag, exp_tag;

  ghr_ckpt_unit #(.GHR_WIDTH(8), .CKPT_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_ready   (pred_ready),
    .pred_tag     (pred_tag),
    .commit_valid (commit_valid),
    .commit_taken (commit_taken),
    .recover_valid(recover_valid),
    .recover_tag  (recover_tag),
    .recover_taken(recover_taken),
    .flush        (flush),
    .ghr_spec     (ghr_spec),
    .ghr_arch     (ghr_arch),
    .ckpt_count   (ckpt_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    pred_valid = 0; pred_taken = 0; commit_valid = 0; commit_taken = 0;
    recover_valid = 0; recover_tag = '0; recover_taken = 0; flush = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_q.delete(); m_head = 0; m_spec = 0; m_arch = 0;
  endtask

  // Apply one cycle of inputs, record pre-edge combinational outputs, advance the model.
  task automatic drive(input bit pv, input bit pt, input bit cv, input bit ct,
                       input bit rv, input int rtag, input bit rt, input bit fl);
    int sz, idx, snap, old_arch;
    pred_valid = pv; pred_taken = pt; commit_valid = cv; commit_taken = ct;
    recover_valid = rv; recover_tag = 3'(rtag); recover_taken = rt; flush = fl;
    #1;
    obs_ready = pred_ready;
    obs_tag   = int'(pred_tag);
    sz        = m_q.size();
    exp_ready = (sz < 8) && !rv && !fl;
    exp_tag   = (m_head + sz) % 8;
    old_arch  = m_arch;
    if (fl) begin
      m_q.delete();
      m_spec = old_arch;
    end else if (rv) begin
      idx = (rtag - m_head + 8) % 8;
      assert (idx < sz) else $error("illegal recover tag %0d", rtag);
      snap = m_q[idx];
      while (m_q.size() > idx + 1) void'(m_q.pop_back());
      m_spec = (snap * 2 + int'(rt)) % 256;
    end else if (exp_ready && pv) begin
      m_q.push_back(m_spec);
      m_spec = (m_spec * 2 + int'(pt)) % 256;
    end
    if (cv && sz > 0) begin
      m_arch = (m_arch * 2 + int'(ct)) % 256;
      m_head = (m_head + 1) % 8;
      if (m_q.size() > 0) void'(m_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ghr_spec !== 8'h00 || ghr_arch !== 8'h00 || ckpt_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: spec=%h arch=%h count=%0d want 0/0/0", ghr_spec, ghr_arch, ckpt_count);
    end
    checks++;
    if (pred_ready !== 1'b1 || pred_tag !== 3'd0) begin
      errors++;
      $display("FAIL reset_ready_tag: ready=%b tag=%0d want 1/0", pred_ready, pred_tag);
    end
  endtask

  task automatic test_predict();
    bit dir[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, dir[i], 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_tag != i || obs_ready !== 1'b1) begin
        errors++;
        $display("FAIL predict_tag%0d: tag=%0d ready=%b want %0d/1", i, obs_tag, obs_ready, i);
      end
    end
    checks++;
    if (ghr_spec !== 8'b0000_0101 || ckpt_count !== 4'd3 || ghr_arch !== 8'h00) begin
      errors++;
      $display("FAIL predict_tnt: spec=%b count=%0d arch=%b want 00000101/3/0", ghr_spec, ckpt_count, ghr_arch);
    end
  endtask

  task automatic test_full();
    logic [7:0] spec_full;
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, i[0], 0, 0, 0, 0, 0, 0);
    spec_full = ghr_spec;
    checks++;
    if (pred_ready !== 1'b0 || ckpt_count !== 4'd8 || spec_full !== 8'b0101_0101) begin
      errors++;
      $display("FAIL full_state: ready=%b count=%0d spec=%b want 0/8/01010101", pred_ready, ckpt_count, spec_full);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_ready !== 1'b0 || ckpt_count !== 4'd8 || ghr_spec !== spec_full || pred_tag !== 3'd0) begin
      errors++;
      $display("FAIL full_ninth_pred: ready=%b count=%0d spec=%b tag=%0d want 0/8/%b/0",
               obs_ready, ckpt_count, ghr_spec, pred_tag, spec_full);
    end
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    commit_valid = 0;
    #1;
    checks++;
    if (pred_ready !== 1'b1 || pred_tag !== 3'd0 || ckpt_count !== 4'd7 || ghr_arch !== 8'h01) begin
      errors++;
      $display("FAIL full_commit: ready=%b tag=%0d count=%0d arch=%b want 1/0/7/00000001",
               pred_ready, pred_tag, ckpt_count, ghr_arch);
    end
  endtask

  task automatic test_recover();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (ghr_spec !== 8'b0000_0010 || ckpt_count !== 4'd2 || pred_tag !== 3'd2) begin
      errors++;
      $display("FAIL recover_tag1: spec=%b count=%0d tag=%0d want 00000010/2/2", ghr_spec, ckpt_count, pred_tag);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (ghr_spec !== 8'b10 || ghr_arch !== 8'b1 || ckpt_count !== 4'd1) begin
      errors++;
      $display("FAIL flush_pre: spec=%b arch=%b count=%0d want 10/1/1", ghr_spec, ghr_arch, ckpt_count);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    flush = 0;
    #1;
    checks++;
    if (ghr_spec !== 8'b1 || ghr_arch !== 8'b1 || ckpt_count !== 4'd0 || pred_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_post: spec=%b arch=%b count=%0d ready=%b want 1/1/0/1",
               ghr_spec, ghr_arch, ckpt_count, pred_ready);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 2, 1, 0);
    checks++;
    if (ckpt_count !== 4'd2 || ghr_arch !== 8'b1 || ghr_spec !== 8'b111 || pred_tag !== 3'd3) begin
      errors++;
      $display("FAIL commit_recover: count=%0d arch=%b spec=%b tag=%0d want 2/1/111/3",
               ckpt_count, ghr_arch, ghr_spec, pred_tag);
    end
    drive(1, 1, 0, 0, 1, 2, 0, 0);
    checks++;
    if (obs_ready !== 1'b0 || ckpt_count !== 4'd2 || ghr_spec !== 8'b110 || pred_tag !== 3'd3) begin
      errors++;
      $display("FAIL pred_recover: ready=%b count=%0d spec=%b tag=%0d want 0/2/110/3",
               obs_ready, ckpt_count, ghr_spec, pred_tag);
    end
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (ghr_arch !== 8'h00 || ckpt_count !== 4'd0 || pred_tag !== 3'd0) begin
      errors++;
      $display("FAIL commit_empty: arch=%b count=%0d tag=%0d want 0/0/0", ghr_arch, ckpt_count, pred_tag);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ghr_spec !== 8'h1f || ckpt_count !== 4'd5) begin
      errors++;
      $display("FAIL rst_mid_pre: spec=%h count=%0d want 1f/5", ghr_spec, ckpt_count);
    end
    pred_valid = 1; pred_taken = 1; commit_valid = 1; commit_taken = 1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; pred_valid = 0; commit_valid = 0;
    m_q.delete(); m_head = 0; m_spec = 0; m_arch = 0;
    checks++;
    if (ghr_spec !== 8'h00 || ghr_arch !== 8'h00 || ckpt_count !== 4'd0 ||
        pred_tag !== 3'd0 || pred_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_post: spec=%h arch=%h count=%0d tag=%0d ready=%b want 0/0/0/0/1",
               ghr_spec, ghr_arch, ckpt_count, pred_tag, pred_ready);
    end
  endtask

  task automatic test_random();
    bit pv, cv, rv, fl;
    int rtag, sz;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sz   = m_q.size();
      pv   = $urandom_range(0, 9) < 6;
      cv   = $urandom_range(0, 9) < 3;
      rv   = (sz > 0) && ($urandom_range(0, 14) == 0);
      fl   = $urandom_range(0, 39) == 0;
      rtag = (sz > 0) ? (m_head + $urandom_range(0, sz - 1)) % 8 : 0;
      drive(pv, 1'($urandom), cv, 1'($urandom), rv, rtag, 1'($urandom), fl);
      checks++;
      if (obs_ready !== exp_ready || obs_tag != exp_tag) begin
        errors++;
        $display("FAIL rand_ready_tag@%0d: ready=%b tag=%0d want %b/%0d", n, obs_ready, obs_tag, exp_ready, exp_tag);
      end
      checks++;
      if (ghr_spec !== 8'(m_spec) || ghr_arch !== 8'(m_arch) || ckpt_count !== 4'(m_q.size())) begin
        errors++;
        $display("FAIL rand_state@%0d: spec=%h arch=%h count=%0d want %h/%h/%0d",
                 n, ghr_spec, ghr_arch, ckpt_count, 8'(m_spec), 8'(m_arch), m_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_predict();
    test_full();
    test_recover();
    test_flush();
    test_simultaneous();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
